// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the CLA sharing arbiter.
// Build option: CLA_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package cla_arb_pkg;

  localparam int CLA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_e;

  // Requester id width; a single requester still needs one bit of id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_tag_pipe.sv
// Ownership tag pipe: shifts {valid, id} alongside the CLA pipeline so each sum
// leaving the adder can be steered to the requester that issued it.
// Build option: none (used identically under CLA_ARB_RR_EN and fixed priority).
module cla_tag_pipe #(
  parameter int LAT  = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vld,
  input  logic [ID_W-1:0] i_id,
  output logic            o_vld,
  output logic [ID_W-1:0] o_id
);

  logic [LAT-1:0]  r_vld;
  logic [ID_W-1:0] r_id [LAT];

  // Shift tags one slot per cycle; reset empties every slot so in-flight sums are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < LAT; s++) r_id[s] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_id[0]  <= i_id;
      for (int s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end

  assign o_vld = r_vld[LAT-1];
  assign o_id  = r_id[LAT-1];

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one pipelined CLA adder between N requesters with valid/ready request
// and response ports. One operand pair is issued per cycle; each requester has at
// most one op outstanding and a one-entry result buffer.
// Build option: CLA_ARB_RR_EN defined -> round-robin search from a rotating pointer;
// undefined -> fixed priority, lowest eligible index wins.
module cla_share_arbiter
  import cla_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 4,
  parameter int W   = CLA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*W-1:0]     req_a,
  input  logic [N*W-1:0]     req_b,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [N*(W+1)-1:0] rsp_sum,
  output logic [W-1:0]       cla_a,
  output logic [W-1:0]       cla_b,
  input  logic [W:0]         cla_out,
  output logic               busy
);

  localparam int ID_W = id_width(N);

  req_state_e      r_state [N];
  logic [W:0]      r_sum   [N];
  logic [W-1:0]    r_cla_a;
  logic [W-1:0]    r_cla_b;

  logic [N-1:0]    w_elig;
  logic [N-1:0]    w_gnt;
  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_tag_vld;
  logic [ID_W-1:0] w_tag_id;

  // A requester may be granted only from IDLE; nothing is eligible while in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N; i++)
      w_elig[i] = req_valid[i] & (r_state[i] == IDLE) & rst_n;
  end

`ifdef CLA_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;
  int              w_idx;

  // Round-robin pick: first eligible requester at or after the pointer, wrapping.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(w_idx);
      end
    end
  end

  // Pointer moves just past the granted requester; it holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (w_gnt_vld)
      r_ptr <= ID_W'((int'(w_gnt_id) + 1) % N);
  end
`else
  // Fixed priority pick: scanning downwards leaves the lowest eligible index.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(k);
      end
    end
  end
`endif

  // One-hot grant vector, doubling as req_ready.
  always_comb begin
    w_gnt = '0;
    if (w_gnt_vld) w_gnt[w_gnt_id] = 1'b1;
  end

  assign req_ready = w_gnt;

  // Operand register feeding the CLA; holds its value in cycles without a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cla_a <= '0;
      r_cla_b <= '0;
    end else if (w_gnt_vld) begin
      r_cla_a <= req_a[int'(w_gnt_id)*W +: W];
      r_cla_b <= req_b[int'(w_gnt_id)*W +: W];
    end
  end

  assign cla_a = r_cla_a;
  assign cla_b = r_cla_b;

  cla_tag_pipe #(
    .LAT  (LAT),
    .ID_W (ID_W)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_gnt_vld),
    .i_id  (w_gnt_id),
    .o_vld (w_tag_vld),
    .o_id  (w_tag_id)
  );

  // Per-requester FSM and result buffer: issue, capture the tagged sum, release on rsp handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= IDLE;
        r_sum[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        case (r_state[i])
          IDLE:     if (w_gnt[i]) r_state[i] <= INFLIGHT;
          INFLIGHT: if (w_tag_vld && (w_tag_id == ID_W'(i))) begin
                      r_state[i] <= DONE;
                      r_sum[i]   <= cla_out;
                    end
          DONE:     if (rsp_ready[i]) r_state[i] <= IDLE;
          default:  r_state[i] <= IDLE;
        endcase
      end
    end
  end

  // Response outputs come straight from the FSM state and result buffers.
  always_comb begin
    rsp_valid = '0;
    rsp_sum   = '0;
    busy      = 1'b0;
    for (int i = 0; i < N; i++) begin
      rsp_valid[i]              = (r_state[i] == DONE);
      rsp_sum[i*(W+1) +: (W+1)] = r_sum[i];
      busy                      = busy | (r_state[i] != IDLE);
    end
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Bench for cla_share_arbiter: directed stimulus with hand-computed sums, a
// behavioural CLA pipeline, and a scoreboard monitor that matches responses.
module tb_cla_share_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int W   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [N*(W+1)-1:0] rsp_sum;
  logic [W-1:0]       cla_a;
  logic [W-1:0]       cla_b;
  logic [W:0]         cla_out;
  logic               busy;

  always #5 clk = ~clk;

  cla_share_arbiter #(.N(N), .LAT(LAT), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_out   (cla_out),
    .busy      (busy)
  );

  // CLA model: sum registered through LAT-1 stages behind the arbiter's operand register.
  logic [W:0] cla_pipe [LAT-1];
  always @(posedge clk) begin
    cla_pipe[0] <= {1'b0, cla_a} + {1'b0, cla_b};
    for (int s = 1; s < LAT - 1; s++) cla_pipe[s] <= cla_pipe[s-1];
  end
  assign cla_out = cla_pipe[LAT-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         cyc;
  } exp_t;

  exp_t       exq[$];
  int         glog_id[$];
  int         glog_cyc[$];
  logic [W:0] r_exp [N];

  // Scoreboard monitor: push on request handshake, pop and compare when rsp_valid rises.
  initial begin
    logic [N-1:0] pv, pr;
    logic [W:0]   ps [N];
    logic         prst;
    int           f;
    pv = '0; pr = '0; prst = 1'b0;
    for (int i = 0; i < N; i++) ps[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exq.delete();
      end else begin
        chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
        chk("ready_implies_valid", 32'(req_ready & ~req_valid), 0);
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            f = -1;
            foreach (exq[k]) if (exq[k].id == i) f = k;
            chk("single_outstanding", 32'(f), 32'hFFFFFFFF);
            exq.push_back('{i, r_exp[i], cyc + 1 + LAT});
            glog_id.push_back(i);
            glog_cyc.push_back(cyc + 1);
          end
          if (rsp_valid[i] && !pv[i]) begin
            f = -1;
            foreach (exq[k]) if (exq[k].id == i) f = k;
            if (f < 0) begin
              chk("spurious_rsp_valid", 32'(rsp_valid[i]), 0);
            end else begin
              chk("rsp_sum", 32'(rsp_sum[i*(W+1) +: (W+1)]), 32'(exq[f].sum));
              chk("rsp_latency", 32'(cyc), 32'(exq[f].cyc));
              exq.delete(f);
            end
          end
          if (prst && pv[i] && !pr[i]) begin
            chk("hold_valid", 32'(rsp_valid[i]), 1);
            chk("hold_sum", 32'(rsp_sum[i*(W+1) +: (W+1)]), 32'(ps[i]));
          end
        end
      end
      pv   = rsp_valid;
      pr   = rsp_ready;
      prst = rst_n;
      for (int i = 0; i < N; i++) ps[i] = rsp_sum[i*(W+1) +: (W+1)];
    end
  end

  int           hs_cnt [N];
  int           rsp_cnt [N];
  int           rereq [N];
  logic [N-1:0] hold;

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] e);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    r_exp[i]        = e;
    req_valid[i]    = 1'b1;
  endtask

  // One clock: observe handshakes before the edge, react to them just after it.
  task automatic tick();
    logic [N-1:0] hs, rh;
    @(negedge clk);
    hs = req_valid & req_ready;
    rh = rsp_valid & rsp_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        hs_cnt[i]++;
        if (!hold[i]) req_valid[i] = 1'b0;
      end
      if (rh[i]) begin
        rsp_cnt[i]++;
        if (rereq[i] > 0) begin
          rereq[i]--;
          req_valid[i] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    hold      = '0;
    for (int i = 0; i < N; i++) begin
      rereq[i] = 0; hs_cnt[i] = 0; rsp_cnt[i] = 0;
    end
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_sum", 32'(rsp_sum[31:0]), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cla_ab", {cla_a, cla_b}, 0);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  task automatic drain(input string nm, input int bound);
    int k = 0;
    while ((busy || (req_valid != '0)) && (k < bound)) begin
      tick();
      k++;
    end
    chk(nm, {27'b0, busy, req_valid}, 0);
  endtask

  initial begin
    int base;
    int k;
    req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0; hold = '0;
    for (int i = 0; i < N; i++) r_exp[i] = '0;

    // Single request: same-cycle grant, sum 50 after LAT cycles.
    reset_dut();
    set_req(0, 16'd38, 16'd12, 17'd50);
    #1;
    chk("t1_ready_same_cycle", 32'(req_ready), 1);
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cla_a", 32'(cla_a), 38);
    chk("t1_cla_b", 32'(cla_b), 12);
    drain("t1_drain", 30);
    chk("t1_rsp_count", 32'(rsp_cnt[0]), 1);

    // All four with max operands: consecutive grants in index order.
    reset_dut();
    base = glog_id.size();
    for (int i = 0; i < N; i++) set_req(i, 16'hFFFF, 16'hFFFF, 17'h1FFFE);
    drain("t2_drain", 40);
    chk("t2_grant_count", 32'(glog_id.size() - base), 4);
    for (int j = 0; j < 4; j++) begin
      if (glog_id.size() > base + j) begin
        chk("t2_order", 32'(glog_id[base+j]), j);
        chk("t2_consecutive", 32'(glog_cyc[base+j] - glog_cyc[base]), j);
      end
    end

    // Arbitration policy: after a grant to 1, requesters 0 and 3 contend.
    reset_dut();
    set_req(1, 16'd5, 16'd6, 17'd11);
    drain("tp_drain1", 30);
    base = glog_id.size();
    set_req(0, 16'd1, 16'd2, 17'd3);
    set_req(3, 16'd7, 16'd8, 17'd15);
    drain("tp_drain2", 30);
    if (glog_id.size() >= base + 2) begin
`ifdef CLA_ARB_RR_EN
      chk("tp_first", 32'(glog_id[base]), 3);
      chk("tp_second", 32'(glog_id[base+1]), 0);
`else
      chk("tp_first", 32'(glog_id[base]), 0);
      chk("tp_second", 32'(glog_id[base+1]), 3);
`endif
    end else begin
      chk("tp_grant_count", 32'(glog_id.size() - base), 2);
    end

    // Req1/req3 held valid, req0 re-requests after its response: grants 0,1,3,0.
    reset_dut();
    hold[1] = 1'b1; hold[3] = 1'b1; rereq[0] = 1;
    base = glog_id.size();
    set_req(0, 16'd100, 16'd200, 17'd300);
    set_req(1, 16'd1000, 16'd2000, 17'd3000);
    set_req(3, 16'h8000, 16'h8000, 17'h10000);
    k = 0;
    while ((glog_id.size() < base + 4) && (k < 40)) begin
      tick();
      k++;
    end
    hold = '0; rereq[0] = 0; req_valid = '0;
    drain("t3_drain", 40);
    chk("t3_grant_count", 32'(glog_id.size() >= base + 4), 1);
    if (glog_id.size() >= base + 4) begin
      chk("t3_g0", 32'(glog_id[base]), 0);
      chk("t3_g1", 32'(glog_id[base+1]), 1);
      chk("t3_g2", 32'(glog_id[base+2]), 3);
      chk("t3_g3", 32'(glog_id[base+3]), 0);
      chk("t3_regrant_cycle", 32'(glog_cyc[base+3] - glog_cyc[base]), 6);
    end

    // Backpressure on requester 2 while the others complete.
    reset_dut();
    rsp_ready[2] = 1'b0;
    set_req(0, 16'd1, 16'd1, 17'd2);
    set_req(1, 16'd2, 16'd3, 17'd5);
    set_req(2, 16'd111, 16'd121, 17'd232);
    set_req(3, 16'd4, 16'd4, 17'd8);
    k = 0;
    while (!rsp_valid[2] && (k < 30)) begin
      tick();
      k++;
    end
    chk("t4_rsp2_valid", 32'(rsp_valid[2]), 1);
    set_req(2, 16'd9, 16'd9, 17'd18);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("t4_hold_valid", 32'(rsp_valid[2]), 1);
      chk("t4_hold_sum", 32'(rsp_sum[2*(W+1) +: (W+1)]), 232);
      chk("t4_no_regrant", 32'(req_ready[2]), 0);
    end
    chk("t4_others_done", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[3]), 3);
    rsp_ready[2] = 1'b1;
    drain("t4_drain", 30);
    chk("t4_rsp2_count", 32'(rsp_cnt[2]), 2);

    // Reset with three ops in flight: nothing stale may surface.
    reset_dut();
    set_req(0, 16'd1, 16'd2, 17'd3);
    set_req(1, 16'd3, 16'd4, 17'd7);
    set_req(2, 16'd5, 16'd6, 17'd11);
    k = 0;
    while ((hs_cnt[2] == 0) && (k < 10)) begin
      tick();
      k++;
    end
    chk("t5_issued", 32'(hs_cnt[0] + hs_cnt[1] + hs_cnt[2]), 3);
    chk("t5_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rsp_valid_after_rst", 32'(rsp_valid), 0);
    chk("t5_busy_after_rst", 32'(busy), 0);
    for (int j = 0; j < LAT + 2; j++) begin
      tick();
      chk("t5_no_stale", 32'(rsp_valid), 0);
    end

    // Lone requester re-requesting: grants spaced by at least LAT+1 cycles.
    reset_dut();
    rereq[3] = 2;
    base = glog_id.size();
    set_req(3, 16'd300, 16'd400, 17'd700);
    drain("t6_drain", 80);
    chk("t6_grant_count", 32'(glog_id.size() - base), 3);
    chk("t6_rsp_count", 32'(rsp_cnt[3]), 3);
    if (glog_id.size() >= base + 3) begin
      for (int j = 1; j < 3; j++) begin
        chk("t6_id", 32'(glog_id[base+j]), 3);
        chk("t6_gap", 32'((glog_cyc[base+j] - glog_cyc[base+j-1]) >= LAT + 1), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
